// File: rtl/mul_share_pkg.sv
// Shared defaults and types for the shared signed multiplier scheduler.
// Widths follow the default 32x27 -> 32 configuration with four requesters.
package mul_share_pkg;

  localparam int unsigned A_W_DEF  = 32;
  localparam int unsigned B_W_DEF  = 27;
  localparam int unsigned P_W_DEF  = 32;
  localparam int unsigned ID_W_DEF = 2;

  typedef logic [ID_W_DEF-1:0] id_t;

  typedef struct packed {
    logic               valid;
    id_t                id;
    logic [P_W_DEF-1:0] p;
  } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search begins one past the last granted index.
// The pointer only moves when a grant is actually taken (en high).
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
        found      = 1'b1;
      end
    end
    ptr_d = (en && found) ? gidx : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PW'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/mul_32s_27s_share_arb.sv
// Shares one signed A_W x B_W multiplier among N_REQ requesters through a
// LAT-stage pipeline that stalls as a whole under response backpressure.
module mul_32s_27s_share_arb
  import mul_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned A_W   = A_W_DEF,
  parameter int unsigned B_W   = B_W_DEF,
  parameter int unsigned P_W   = P_W_DEF,
  parameter int unsigned LAT   = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*A_W-1:0] req_a,
  input  logic [N_REQ*B_W-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [P_W-1:0]     rsp_p,
  output logic               busy
);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } pipe_t;

  pipe_t stage_q [LAT];

  logic                        adv, en, accept;
  logic [N_REQ-1:0]            grant;
  logic [$clog2(N_REQ)-1:0]    arb_ptr;
  logic                        unused_ptr;
  logic signed [A_W-1:0]       a_sel;
  logic signed [B_W-1:0]       b_sel;
  logic [ID_W-1:0]             id_sel;
  logic signed [A_W+B_W-1:0]   full;

  assign adv       = !stage_q[LAT-1].valid || rsp_ready;
  assign en        = adv && !ap_rst;
  assign req_ready = grant & {N_REQ{en}};
  assign accept    = |req_ready;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .clk   (ap_clk),
    .rst   (ap_rst),
    .req   (req_valid),
    .en    (en),
    .grant (grant),
    .ptr   (arb_ptr)
  );

  assign unused_ptr = ^arb_ptr;

  // Grant is one-hot, so an OR-style mux is sufficient.
  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    id_sel = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) begin
        a_sel  = req_a[i*A_W +: A_W];
        b_sel  = req_b[i*B_W +: B_W];
        id_sel = ID_W'(i);
      end
    end
    full = (A_W+B_W)'(a_sel) * (A_W+B_W)'(b_sel);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < int'(LAT); i++) begin
        stage_q[i] <= '0;
      end
    end else if (adv) begin
      stage_q[0].valid <= accept;
      stage_q[0].id    <= id_sel;
      stage_q[0].p     <= full[P_W-1:0];
      for (int i = 1; i < int'(LAT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      busy = busy | stage_q[i].valid;
    end
  end

  assign rsp_valid = stage_q[LAT-1].valid;
  assign rsp_id    = stage_q[LAT-1].id;
  assign rsp_p     = stage_q[LAT-1].p;

endmodule
